// File: rtl/ac97_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ac97_cmd_arbiter
// Shares the AC97 codec command channel (out slot1 address / slot2 data)
// among NREQ requesters. One register read or write is issued per frame;
// read responses are taken from input slots 1/2. Each transaction ends with
// a one-cycle done pulse to its requester, with err flagging a read timeout.
//
// Ports
//   ac97_bitclk, ac97_rst_n      bit clock, async active-low reset
//   ac97_strobe                  one-cycle frame boundary pulse
//   req/req_rw/req_addr/req_wdata  per-requester command (packed, 7/16 bits each)
//   done/err/rdata/busy          completion reporting
//   ac97_out_slot1/2(_valid)     command slots toward the framer
//   ac97_in_slot1/2(_valid)      status slots from the deframer
// ---------------------------------------------------------------------------
module ac97_cmd_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                 ac97_bitclk,
    input  logic                 ac97_rst_n,
    input  logic                 ac97_strobe,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic                 busy,
    output logic [19:0]          ac97_out_slot1,
    output logic                 ac97_out_slot1_valid,
    output logic [19:0]          ac97_out_slot2,
    output logic                 ac97_out_slot2_valid,
    input  logic [19:0]          ac97_in_slot1,
    input  logic                 ac97_in_slot1_valid,
    input  logic [19:0]          ac97_in_slot2,
    input  logic                 ac97_in_slot2_valid
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t            r_state, w_next_state;
    logic [IW-1:0]     r_grant, r_ptr;
    logic              r_rw;
    logic [6:0]        r_addr;
    logic [15:0]       r_wdata;
    logic [7:0]        r_timer;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic [15:0]       r_rdata;
    logic [19:0]       r_slot1, r_slot2;
    logic              r_slot1_v, r_slot2_v;

    logic              w_match, w_timeout, w_complete, w_load, w_found;
    logic [NREQ-1:0]   w_gvec, w_mask;
    logic [IW-1:0]     w_pick, w_idx;
    logic [IW:0]       w_sum;
    logic              w_prw;
    logic [6:0]        w_paddr;
    logic [15:0]       w_pwdata;

    assign w_gvec    = NREQ'(1) << r_grant;
    assign w_match   = ac97_in_slot1_valid & ac97_in_slot2_valid &
                       (ac97_in_slot1[18:12] == r_addr);
    assign w_timeout = (r_timer == 8'(TIMEOUT_FRAMES - 1));
    assign w_complete = ac97_strobe &
                        (((r_state == ISSUE) & ~r_rw) |
                         ((r_state == WAIT_RD) & (w_match | w_timeout)));
    // The finishing requester may still hold req this strobe; keep it out.
    assign w_mask    = w_complete ? w_gvec : '0;
    assign w_load    = ac97_strobe & w_found & ((r_state == IDLE) | w_complete);

    // Round-robin search starting at r_ptr, plus mux of the winner's args.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_sum    = '0;
        w_idx    = '0;
        w_prw    = 1'b0;
        w_paddr  = '0;
        w_pwdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + IW1'(k);
            if (w_sum >= IW1'(NREQ)) begin
                w_sum = w_sum - IW1'(NREQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && req[w_idx] && !w_mask[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == w_pick) begin
                w_prw    = req_rw[i];
                w_paddr  = req_addr[7*i +: 7];
                w_pwdata = req_wdata[16*i +: 16];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_load) begin
            w_next_state = ISSUE;
        end else if (w_complete) begin
            w_next_state = IDLE;
        end else if (ac97_strobe && r_state == ISSUE && r_rw) begin
            w_next_state = WAIT_RD;
        end
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_rst_n) begin
        if (!ac97_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_rst_n) begin
        if (!ac97_rst_n) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_timer   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_slot1   <= '0;
            r_slot2   <= '0;
            r_slot1_v <= 1'b0;
            r_slot2_v <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_complete) begin
                r_done <= w_gvec;
                // Write completions leave rdata untouched.
                if (r_state == WAIT_RD) begin
                    r_err   <= ~w_match;
                    r_rdata <= w_match ? ac97_in_slot2[19:4] : 16'hFFFF;
                end
            end
            if (ac97_strobe) begin
                if (w_load) begin
                    r_grant   <= w_pick;
                    r_ptr     <= (w_pick == IW'(NREQ - 1)) ? '0 : w_pick + IW'(1);
                    r_rw      <= w_prw;
                    r_addr    <= w_paddr;
                    r_wdata   <= w_pwdata;
                    r_slot1   <= {w_prw, w_paddr, 12'h000};
                    r_slot2   <= w_prw ? 20'h0 : {w_pwdata, 4'h0};
                    r_slot1_v <= 1'b1;
                    r_slot2_v <= 1'b1;
                end else begin
                    r_slot1   <= '0;
                    r_slot2   <= '0;
                    r_slot1_v <= 1'b0;
                    r_slot2_v <= 1'b0;
                end
                if (r_state == ISSUE) begin
                    r_timer <= '0;
                end else if (r_state == WAIT_RD && !w_complete) begin
                    r_timer <= r_timer + 8'd1;
                end
            end
        end
    end

    assign done                 = r_done;
    assign err                  = r_err;
    assign rdata                = r_rdata;
    assign busy                 = (r_state != IDLE);
    assign ac97_out_slot1       = r_slot1;
    assign ac97_out_slot1_valid = r_slot1_v;
    assign ac97_out_slot2       = r_slot2;
    assign ac97_out_slot2_valid = r_slot2_v;

endmodule
